// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues sequential SRAM reads, buffers results
// in a small prefetch FIFO and hands them downstream with valid/ready.
// Ports: clk, rst (async, active high); instsram_ctrl/instsram_q to the
// instruction SRAM; inst/inst_pc/inst_valid/inst_ready to the controller;
// redirect/redirect_pc restart fetch; halt stops new reads.
module inst_fetch #(
  parameter int ADDR_W = 11,
  parameter int INST_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W+1:0] instsram_ctrl,
  input  logic [INST_W-1:0] instsram_q,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0] DEPTH_O = (PW+2)'(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rd_pc_q, rd_pc_d;
  logic              rd_pend_q, rd_pend_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [PW:0]       count_q, count_d;
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];

  logic [ADDR_W-1:0] addr;
  logic [PW+1:0]     occ;
  logic              issue;
  logic              push;
  logic              pop;

  assign inst_valid    = (count_q != '0);
  assign inst          = inst_mem_q[head_q];
  assign inst_pc       = pc_mem_q[head_q];
  assign instsram_ctrl = {1'b1, ~issue, addr};

  always_comb begin
    occ  = {1'b0, count_q} + {{(PW+1){1'b0}}, rd_pend_q};
    addr = fetch_pc_q;
    if (rst)
      addr = '0;
    else if (redirect)
      addr = redirect_pc;
    // A redirect empties the FIFO, so it always has room for its own read.
    issue = !rst && !halt && (redirect || (occ < DEPTH_O));
    push  = rd_pend_q && !redirect;
    pop   = inst_valid && inst_ready && !redirect;

    fetch_pc_d = fetch_pc_q;
    if (issue)
      fetch_pc_d = addr + ADDR_W'(1);
    else if (redirect)
      fetch_pc_d = redirect_pc;
    rd_pend_d = issue;
    rd_pc_d   = issue ? addr : rd_pc_q;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)
        head_d = head_q + PW'(1);
      if (push)
        tail_d = tail_q + PW'(1);
      if (push && !pop)
        count_d = count_q + (PW+1)'(1);
      else if (pop && !push)
        count_d = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= '0;
      rd_pc_q    <= '0;
      rd_pend_q  <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_pc_q    <= rd_pc_d;
      rd_pend_q  <= rd_pend_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      if (push) begin
        pc_mem_q[tail_q]   <= rd_pc_q;
        inst_mem_q[tail_q] <= instsram_q;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count_q == DEPTH_C));

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage sitting directly upstream of the BNN controller. Owns the instruction SRAM port, streams sequential 16-bit instructions from it through a small prefetch FIFO, and presents them to the controller with a valid/ready handshake. Hides the SRAM's one-cycle read latency, absorbs controller stalls, and supports a redirect (jump) that flushes all in-flight fetches and restarts at a new address.

## Interface

- ADDR_W, 11, instruction SRAM address width (word address)
- INST_W, 16, instruction width
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- instsram_ctrl  out  ADDR_W+2  [ADDR_W-1:0] read address, [ADDR_W] CEN (active low), [ADDR_W+1] WEN (1 = read; always 1)
- instsram_q  in  INST_W  SRAM read data, valid the cycle after CEN=0
- inst  out  INST_W  instruction at FIFO head
- inst_pc  out  ADDR_W  address that inst was fetched from
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  controller consumes head this cycle when inst_valid=1
- redirect  in  1  jump taken: flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  restart address
- halt  in  1  suppress new SRAM reads (drain only)

## Operation

- State: fetch_pc (next address to read), rd_pend (read issued last cycle), rd_pc (its address), FIFO of DEPTH entries {pc, inst}, count 0..DEPTH.
- Issue condition (combinational): issue = !rst & !halt & (count + rd_pend < DEPTH). Counts current occupancy only; a same-cycle pop does not create credit.
- instsram_ctrl = {1'b1, ~issue, addr}; addr = redirect ? redirect_pc : fetch_pc. CEN=1 whenever not issuing.
- On issue: fetch_pc <= addr + 1, modulo 2^ADDR_W (0x7FF wraps to 0x000); rd_pend <= 1, rd_pc <= addr. Else rd_pend <= 0.
- Push: if rd_pend & !redirect, write {rd_pc, instsram_q} to FIFO tail.
- Pop: inst_valid & inst_ready & !redirect advances head.
- Push and pop in the same cycle: count unchanged, both happen. Overflow cannot occur by the issue rule; push when full is a design error (verification asserts it never happens).
- Redirect (cycle t): FIFO cleared (count <= 0), data landing in cycle t discarded, any pop ignored; if !halt, a read of redirect_pc is issued in cycle t and kept. Redirect overrides halt for the fetch_pc update: with halt=1, fetch_pc <= redirect_pc, no read issued.
- halt: no new reads; a read already pending still lands; FIFO keeps draining. On deassertion, fetch resumes at fetch_pc.
- inst, inst_pc, inst_valid come from FIFO head registers (no combinational path from instsram_q or inst_ready).

## Timing

- Reset (asynchronous, any time, including mid-read or mid-redirect): fetch_pc=0, rd_pend=0, count=0; inst_valid=0, inst=0, inst_pc=0; instsram_ctrl=13'h1800 (WEN=1, CEN=1, addr 0) while rst high. In-flight read is abandoned.
- First cycle after rst falls (cycle 0): CEN=0, addr 0. Data lands cycle 1; inst_valid=1 in cycle 2 with inst_pc=0.
- Fetch-to-valid latency: 2 cycles. Sustained throughput with inst_ready=1: one instruction per cycle.
- Redirect in cycle t (halt=0): inst_valid=0 in t+1; inst_valid=1 in t+2 with inst_pc=redirect_pc.
- With inst_ready=0 from the start: reads issued for addresses 0..3 only, count reaches 4, CEN held 1 thereafter.

## Test plan

- Reset release, inst_ready=1, SRAM model mem[i]=16'hA000+i: inst_valid first high cycle 2; inst=A000,A001,A002… one per cycle, inst_pc=0,1,2…, no gaps.
- inst_ready=0 for 10 cycles after reset: exactly 4 reads (addr 0..3), then CEN=1; raise inst_ready: A000..A003 then A004… in order, no duplicates or loss.
- Redirect to 0x100 while count=3 and a read pending: cycle t+1 inst_valid=0; t+2 inst=mem[0x100], inst_pc=0x100; stale A00x never appears.
- Redirect to 0x7FE, inst_ready=1: inst_pc sequence 0x7FE, 0x7FF, 0x000, 0x001.
- halt=1 with full FIFO and inst_ready=1: CEN stays 1, 4 instructions drain then inst_valid=0; halt=0 resumes at next sequential address.
- Assert rst mid-stream with pending read: outputs reset asynchronously (inst_valid=0, instsram_ctrl=13'h1800); after release fetch restarts at addr 0 with first valid in cycle 2.
